// File: rtl/mem_ctrl.sv
// mem_ctrl: fixed-latency line memory behind a single-request handshake.
// Each accepted request is held for LATENCY cycles and then answered with a
// one-cycle ready pulse. Writes commit to the line array at the end of the
// response cycle.
// Ports:
//   clk_i, rst_i           clock, synchronous active-high reset
//   mem_req_valid_i        request strobe, sampled only in IDLE
//   mem_req_rw_i           1 = write line, 0 = read line
//   mem_req_addr_i[31:0]   byte address; the line index is taken above bit 3
//   mem_req_data_i[127:0]  write line
//   mem_data_o[127:0]      response line; zero outside the response cycle
//   mem_ready_o            one-cycle completion pulse
//   busy_o                 a request is being held
//   no_rd_o, no_wr_o       completed read / write counts (wrap silently)
module mem_ctrl #(
  parameter int unsigned LATENCY   = 4,
  parameter int unsigned MEM_LINES = 1024
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         mem_req_valid_i,
  input  logic         mem_req_rw_i,
  input  logic [31:0]  mem_req_addr_i,
  input  logic [127:0] mem_req_data_i,
  output logic [127:0] mem_data_o,
  output logic         mem_ready_o,
  output logic         busy_o,
  output logic [31:0]  no_rd_o,
  output logic [31:0]  no_wr_o
);

  localparam int unsigned LINE_W = 128;
  localparam int unsigned IDX_W  = $clog2(MEM_LINES);
  localparam int unsigned CNT_W  = 4;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_rw;
  logic [IDX_W-1:0]   r_idx;
  logic [LINE_W-1:0]  r_wdata;
  logic [LINE_W-1:0]  r_data;
  logic               r_ready;
  logic               r_busy;
  logic [31:0]        r_nrd;
  logic [31:0]        r_nwr;
  logic [LINE_W-1:0]  r_mem [MEM_LINES];

  // Address bits outside the line index only alias; they carry no state.
  logic w_unused_addr;
  assign w_unused_addr = ^{mem_req_addr_i[31:IDX_W+4], mem_req_addr_i[3:0]};

  assign mem_data_o  = r_data;
  assign mem_ready_o = r_ready;
  assign busy_o      = r_busy;
  assign no_rd_o     = r_nrd;
  assign no_wr_o     = r_nwr;

  // Line array: not reset; a reset during RESP suppresses the pending commit.
  always_ff @(posedge clk_i) begin
    if (!rst_i && r_state == S_RESP && r_rw) begin
      r_mem[r_idx] <= r_wdata;
    end
  end

  // Request FSM with registered outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_rw    <= 1'b0;
      r_idx   <= '0;
      r_wdata <= '0;
      r_data  <= '0;
      r_ready <= 1'b0;
      r_busy  <= 1'b0;
      r_nrd   <= '0;
      r_nwr   <= '0;
    end else begin
      r_ready <= 1'b0;
      r_data  <= '0;
      case (r_state)
        S_IDLE: begin
          if (mem_req_valid_i) begin
            r_rw    <= mem_req_rw_i;
            r_idx   <= mem_req_addr_i[IDX_W+3:4];
            r_wdata <= mem_req_data_i;
            r_cnt   <= CNT_W'(LATENCY - 1);
            r_busy  <= 1'b1;
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (r_cnt == '0) begin
            // No write can land before RESP ends, so sampling the array here
            // equals its contents during the RESP cycle.
            r_data  <= r_rw ? r_wdata : r_mem[r_idx];
            r_ready <= 1'b1;
            r_state <= S_RESP;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        S_RESP: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
          if (r_rw) r_nwr <= r_nwr + 32'd1;
          else      r_nrd <= r_nrd + 32'd1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: one LATENCY=4 instance and one LATENCY=1
// instance, compared each cycle against an associative-array line model.
module tb_mem_ctrl;

  localparam int unsigned LINES = 1024;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         v   [2];
  logic         rw  [2];
  logic [31:0]  a   [2];
  logic [127:0] d   [2];
  logic [127:0] q   [2];
  logic         rdy [2];
  logic         bsy [2];
  logic [31:0]  nrd [2];
  logic [31:0]  nwr [2];

  mem_ctrl #(.LATENCY(4), .MEM_LINES(LINES)) u_l4 (
    .clk_i(clk), .rst_i(rst),
    .mem_req_valid_i(v[0]), .mem_req_rw_i(rw[0]),
    .mem_req_addr_i(a[0]), .mem_req_data_i(d[0]),
    .mem_data_o(q[0]), .mem_ready_o(rdy[0]), .busy_o(bsy[0]),
    .no_rd_o(nrd[0]), .no_wr_o(nwr[0]));

  mem_ctrl #(.LATENCY(1), .MEM_LINES(LINES)) u_l1 (
    .clk_i(clk), .rst_i(rst),
    .mem_req_valid_i(v[1]), .mem_req_rw_i(rw[1]),
    .mem_req_addr_i(a[1]), .mem_req_data_i(d[1]),
    .mem_data_o(q[1]), .mem_ready_o(rdy[1]), .busy_o(bsy[1]),
    .no_rd_o(nrd[1]), .no_wr_o(nwr[1]));

  int checks = 0;
  int errors = 0;
  logic [127:0] mdl [int];   // key = instance*LINES + line index
  int erd [2];
  int ewr [2];

  task automatic chk(input string tag, input logic [127:0] o, input logic [127:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  function automatic int key_of(input int s, input logic [31:0] addr);
    return s * int'(LINES) + int'((addr / 32'd16) % LINES);
  endfunction

  task automatic chk_counts(input int s);
    chk("no_rd", 128'(nrd[s]), 128'(erd[s]));
    chk("no_wr", 128'(nwr[s]), 128'(ewr[s]));
  endtask

  // Issue one request from a negedge with the instance idle; returns at the
  // negedge after the counters have updated.
  task automatic req(input int s, input logic wr, input logic [31:0] addr,
                     input logic [127:0] data, input bit scramble);
    int lat = (s == 0) ? 4 : 1;
    int k = key_of(s, addr);
    bit known = wr || mdl.exists(k);
    logic [127:0] expq = wr ? data : (mdl.exists(k) ? mdl[k] : 128'h0);
    v[s] = 1'b1; rw[s] = wr; a[s] = addr; d[s] = data;
    for (int n = 1; n <= lat + 2; n++) begin
      @(negedge clk);
      if (n == 1) begin
        v[s] = 1'b0;
        if (scramble) begin
          rw[s] = 1'b1; a[s] = $urandom;
          d[s] = {$urandom, $urandom, $urandom, $urandom};
        end
      end
      chk("ready", 128'(rdy[s]), 128'(n == lat + 1));
      chk("busy", 128'(bsy[s]), 128'(n <= lat + 1));
      if (n != lat + 1) chk("data_zero", q[s], 128'h0);
      else if (known) chk("resp_data", q[s], expq);
      if (n == lat + 1 && wr) mdl[k] = data;
    end
    if (wr) ewr[s]++; else erd[s]++;
    chk_counts(s);
  endtask

  // Three reads with valid held high: pulses 6 cycles apart, one idle cycle between.
  task automatic back_to_back(input logic [31:0] addr);
    int k = key_of(0, addr);
    v[0] = 1'b1; rw[0] = 1'b0; a[0] = addr;
    for (int n = 1; n <= 19; n++) begin
      @(negedge clk);
      if (n == 17) v[0] = 1'b0;
      chk("b2b_ready", 128'(rdy[0]), 128'(n <= 17 && n % 6 == 5));
      chk("b2b_busy", 128'(bsy[0]), 128'(n <= 17 && n % 6 != 0));
      if (rdy[0] === 1'b1) chk("b2b_data", q[0], mdl[k]);
    end
    erd[0] += 3;
    chk_counts(0);
  endtask

  logic [127:0] line_a, line_b;
  logic [31:0]  raddr;

  initial begin
    rst = 1'b1;
    for (int s = 0; s < 2; s++) begin
      v[s] = 1'b0; rw[s] = 1'b0; a[s] = '0; d[s] = '0; erd[s] = 0; ewr[s] = 0;
    end
    // Requests during reset are ignored.
    v[0] = 1'b1; rw[0] = 1'b1; a[0] = 32'h40;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      for (int s = 0; s < 2; s++) begin
        chk("rst_busy", 128'(bsy[s]), 128'h0);
        chk("rst_ready", 128'(rdy[s]), 128'h0);
        chk("rst_data", q[s], 128'h0);
        chk_counts(s);
      end
    end
    rst = 1'b0;

    // Write then read of the same line via a different byte offset.
    req(0, 1'b1, 32'h0000_0040, 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D, 1'b0);
    req(0, 1'b0, 32'h0000_004C, 128'h0, 1'b0);
    chk("dir_rd_cnt", 128'(nrd[0]), 128'd1);
    chk("dir_wr_cnt", 128'(nwr[0]), 128'd1);

    // Aliasing: 0x4010 maps onto line 1.
    line_a = 128'hAAAA_0001_AAAA_0002_AAAA_0003_AAAA_0004;
    line_b = 128'hBBBB_0001_BBBB_0002_BBBB_0003_BBBB_0004;
    req(0, 1'b1, 32'h0000_0010, line_a, 1'b0);
    req(0, 1'b1, 32'h0000_4010, line_b, 1'b0);
    req(0, 1'b0, 32'h0000_0010, 128'h0, 1'b0);

    // Inputs changing during WAIT are ignored.
    req(0, 1'b1, 32'h0000_0020, 128'h2222_3333_4444_5555_6666_7777_8888_9999, 1'b0);
    req(0, 1'b0, 32'h0000_0020, 128'h0, 1'b1);
    req(0, 1'b0, 32'h0000_0020, 128'h0, 1'b0);

    back_to_back(32'h0000_0020);

    // Reset in WAIT aborts a write.
    req(0, 1'b1, 32'h0000_0030, 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677, 1'b0);
    v[0] = 1'b1; rw[0] = 1'b1; a[0] = 32'h30; d[0] = {4{32'h5A5A_A5A5}};
    @(negedge clk);
    v[0] = 1'b0;
    @(negedge clk);
    chk("abort_busy_pre", 128'(bsy[0]), 128'h1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int s = 0; s < 2; s++) begin erd[s] = 0; ewr[s] = 0; end
    chk("abort_busy", 128'(bsy[0]), 128'h0);
    chk("abort_ready", 128'(rdy[0]), 128'h0);
    chk_counts(0);
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      chk("abort_no_ready", 128'(rdy[0]), 128'h0);
    end
    req(0, 1'b0, 32'h0000_0030, 128'h0, 1'b0);

    // Random traffic over a few lines with aliasing high bits.
    for (int i = 0; i < 40; i++) begin
      raddr = ($urandom & 32'hFFFF_C00F) | (32'($urandom_range(0, 7)) << 4);
      req(0, 1'($urandom_range(0, 1)), raddr,
          {$urandom, $urandom, $urandom, $urandom}, 1'($urandom_range(0, 1)));
    end

    // LATENCY=1 instance.
    req(1, 1'b1, 32'h0000_0050, 128'h1111_2222_3333_4444_5555_6666_7777_8888, 1'b0);
    req(1, 1'b0, 32'h0000_0050, 128'h0, 1'b0);
    for (int i = 0; i < 12; i++) begin
      raddr = ($urandom & 32'hFFFF_C00F) | (32'($urandom_range(0, 3)) << 4);
      req(1, 1'($urandom_range(0, 1)), raddr,
          {$urandom, $urandom, $urandom, $urandom}, 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_ctrl.md
MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 Parameter LATENCY, default 4, cycles from request acceptance to response; legal range 1..15.
REQ-002 Parameter MEM_LINES, default 1024, number of 128-bit lines in backing store; power of two.
REQ-003 clk_i  input  1  single clock; all state updates on rising edge.
REQ-004 rst_i  input  1  reset, synchronous, active-high.
REQ-005 mem_req_valid_i  input  1  cache requests a line transfer.
REQ-006 mem_req_rw_i  input  1  1 = write line to memory, 0 = read line.
REQ-007 mem_req_addr_i  input  32  byte address; bits [3:0] ignored (line-aligned).
REQ-008 mem_req_data_i  input  128  line to write; ignored for reads.
REQ-009 mem_data_o  output  128  returned line.
REQ-010 mem_ready_o  output  1  one-cycle pulse: request completed, mem_data_o valid.
REQ-011 busy_o  output  1  high while a request is held (WAIT or RESP).
REQ-012 no_rd_o  output  32  count of completed reads.
REQ-013 no_wr_o  output  32  count of completed writes.

Function
REQ-014 FSM states IDLE, WAIT, RESP.
REQ-015 IDLE: mem_req_valid_i=1 -> latch rw, addr[31:4], data; load counter with LATENCY-1; go WAIT. Otherwise stay IDLE.
REQ-016 Acceptance occurs only in IDLE; request inputs changing during WAIT/RESP are ignored (latched copy used).
REQ-017 WAIT: counter 0 -> go RESP; else decrement, stay WAIT.
REQ-018 RESP: mem_ready_o=1 for exactly this cycle; next state IDLE unconditionally.
REQ-019 Request-to-ready latency: ready asserted LATENCY+1 cycles after acceptance edge (LATENCY=4: accept cycle 0, ready cycle 5).
REQ-020 Line index = latched addr[log2(MEM_LINES)+3:4]; higher address bits ignored (aliasing/wrap-around, no error).
REQ-021 Write: array[index] <= latched data at the clock edge ending RESP; mem_data_o in RESP = latched write data.
REQ-022 Read: mem_data_o in RESP = array[index] as of RESP cycle (includes any write committed earlier).
REQ-023 mem_data_o outside RESP SHALL be 128'h0.
REQ-024 Back-to-back: valid held high through RESP -> new request accepted in the IDLE cycle after RESP; minimum spacing between ready pulses is LATENCY+2 cycles.
REQ-025 Write followed immediately by read of same line returns the new data (write commits before next acceptance).
REQ-026 no_rd_o/no_wr_o increment by 1 at end of RESP per rw; wrap 32'hFFFFFFFF -> 0 silently.
REQ-027 busy_o = 1 in WAIT and RESP, 0 in IDLE.

Reset
REQ-028 rst_i=1 at a rising edge: state IDLE, counter 0, mem_ready_o=0, busy_o=0, mem_data_o=0, no_rd_o=0, no_wr_o=0 from the next cycle.
REQ-029 Reset mid-operation (WAIT or RESP) aborts the request: no ready pulse, pending write not committed, counters not incremented.
REQ-030 Memory array contents are not affected by reset; contents before first write are undefined.
REQ-031 Request valid while rst_i=1 is ignored; acceptance possible on first edge with rst_i=0.

Verification
REQ-032 Write 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D to addr 32'h0000_0040, then read addr 32'h0000_004C -> read returns same line; ready pulses 5 cycles after each acceptance; no_wr_o=1, no_rd_o=1.
REQ-033 Write line A to addr 32'h0000_0010, write line B to addr 32'h0000_4010 (MEM_LINES=1024, aliases index 1), read 32'h0000_0010 -> returns B.
REQ-034 Hold valid=1, rw=0 continuously for 3 requests -> exactly 3 single-cycle ready pulses spaced 6 cycles apart; busy_o low one cycle between each.
REQ-035 Accept write, assert rst_i in WAIT cycle 2 -> no ready pulse, busy_o=0 after reset, counters 0; subsequent read of that line returns prior contents (previously written value), not the aborted data.
REQ-036 Change addr/data/rw during WAIT after accepting read of 32'h0000_0020 -> response reflects original read of line index 2; no write occurs.
REQ-037 LATENCY=1 build: accept -> ready exactly 2 cycles later; mem_data_o=0 in all non-RESP cycles.
